// File: rtl/draw_engine.sv
// Region scanner: walks a sprite or full-screen region, issues pixel-memory
// addresses and emits clipped VGA pixel writes aligned to a 1-cycle memory.
module draw_engine #(
  parameter int SPR_W = 40,
  parameter int SPR_H = 40,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        fullScreen,
  input  logic [7:0]  xInit,
  input  logic [6:0]  yInit,
  input  logic [2:0]  pixelColor,
  output logic [14:0] romAddr,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  // state  | meaning
  // IDLE   | waiting for start
  // SCAN   | issuing one pixel address per cycle
  // FLUSH  | two cycles draining the memory/plot pipeline
  // FINISH | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, FINISH} stateType;

  localparam logic [7:0] SCR_W8 = 8'(SCR_W);
  localparam logic [6:0] SCR_H7 = 7'(SCR_H);
  localparam logic [7:0] SPR_W8 = 8'(SPR_W);
  localparam logic [6:0] SPR_H7 = 7'(SPR_H);
  localparam logic [8:0] SCR_W9 = 9'(SCR_W);
  localparam logic [7:0] SCR_H8 = 8'(SCR_H);

  stateType state, nextState;

  logic       mode;
  logic [7:0] xOrg;
  logic [6:0] yOrg;
  logic [7:0] col;
  logic [6:0] row;
  logic       flushCnt;
  logic       vld1;
  logic [8:0] px1;
  logic [7:0] py1;

  logic [7:0] wCur;
  logic [6:0] hCur;
  logic       lastCol, lastRow, accept, issue;

  assign wCur    = mode ? SCR_W8 : SPR_W8;
  assign hCur    = mode ? SCR_H7 : SPR_H7;
  assign lastCol = (col == wCur - 8'd1);
  assign lastRow = (row == hCur - 7'd1);
  assign accept  = (state == IDLE) && start;
  assign issue   = (state == SCAN);
  assign busy    = (state != IDLE);
  assign done    = (state == FINISH);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = SCAN;
      SCAN:    if (lastCol && lastRow) nextState = FLUSH;
      FLUSH:   if (flushCnt) nextState = FINISH;
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode     <= 1'b0;
      xOrg     <= '0;
      yOrg     <= '0;
      col      <= '0;
      row      <= '0;
      romAddr  <= '0;
      flushCnt <= 1'b0;
      vld1     <= 1'b0;
      px1      <= '0;
      py1      <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
    end else begin
      if (accept) begin
        mode    <= fullScreen;
        xOrg    <= fullScreen ? 8'd0 : xInit;
        yOrg    <= fullScreen ? 7'd0 : yInit;
        col     <= '0;
        row     <= '0;
        romAddr <= '0;
      end else if (issue) begin
        if (lastCol) begin
          col <= '0;
          if (!lastRow) row <= row + 7'd1;
        end else begin
          col <= col + 8'd1;
        end
        // Row-major order makes row*W+col a plain increment; hold on the last pixel.
        if (!(lastCol && lastRow)) romAddr <= romAddr + 15'd1;
      end

      flushCnt <= (state == FLUSH) ? ~flushCnt : 1'b0;

      vld1   <= issue;
      px1    <= {1'b0, xOrg} + {1'b0, col};
      py1    <= {1'b0, yOrg} + {1'b0, row};

      x      <= px1[7:0];
      y      <= py1[6:0];
      colour <= pixelColor;
      plot   <= vld1 && (px1 < SCR_W9) && (py1 < SCR_H8);
    end
  end

endmodule
